// File: rtl/twop_rf_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 64x32 two-port register-file macro.
// The RF holds the bulk of the data; a 2-entry output buffer hides the macro's 1-cycle read latency.

module twop_rf_fifo_ctrl #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [DW-1:0] push_data_i,
    output logic          pop_valid_o,
    input  logic          pop_ready_i,
    output logic [DW-1:0] pop_data_o,
    output logic [AW+1:0] count_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_wr_addr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic          rf_re_o,
    output logic [AW-1:0] rf_rd_addr_o,
    input  logic [DW-1:0] rf_rdata_i
);
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] MEM_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   mem_cnt_r;
    logic          inflight_r;
    logic [1:0]    ob_cnt_r;
    logic [DW-1:0] ob_r [0:1];

    logic          push_fire_s;
    logic          pop_fire_s;
    logic [2:0]    ob_occ_s;
    logic          rd_issue_s;
    logic          ld_idx_s;

    assign push_ready_o = (mem_cnt_r != MEM_FULL) & ~flush_i;
    assign push_fire_s  = push_valid_i & push_ready_o;
    assign pop_valid_o  = (ob_cnt_r != 2'd0);
    assign pop_fire_s   = pop_valid_o & pop_ready_i;

    assign rf_we_o      = push_fire_s;
    assign rf_wr_addr_o = wr_ptr_r;
    assign rf_wdata_o   = push_data_i;
    assign rf_re_o      = rd_issue_s;
    assign rf_rd_addr_o = rd_ptr_r;
    assign pop_data_o   = ob_r[0];

    assign count_o = {1'b0, mem_cnt_r}
                   + {{(AW+1){1'b0}}, inflight_r}
                   + {{AW{1'b0}}, ob_cnt_r};

    // Issue a read only when the output buffer has room for the word next cycle
    always_comb begin
        ob_occ_s   = {1'b0, ob_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_fire_s};
        rd_issue_s = 1'b0;
        ld_idx_s   = 1'b0;
        if (!flush_i && (mem_cnt_r != {(AW+1){1'b0}}) && (ob_occ_s <= 3'd1)) begin
            rd_issue_s = 1'b1;
        end else begin
            rd_issue_s = 1'b0;
        end
        if ((ob_cnt_r == 2'd1) && !pop_fire_s) begin
            ld_idx_s = 1'b1;
        end else begin
            ld_idx_s = 1'b0;
        end
    end

    // Pointers, occupancy counters and read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            mem_cnt_r  <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            ob_cnt_r   <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            mem_cnt_r  <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            ob_cnt_r   <= 2'd0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            mem_cnt_r  <= mem_cnt_r + (AW+1)'(push_fire_s) - (AW+1)'(rd_issue_s);
            inflight_r <= rd_issue_s;
            ob_cnt_r   <= ob_cnt_r + {1'b0, inflight_r} - {1'b0, pop_fire_s};
        end
    end

    // Output buffer: shift on pop, then land the returning RF word behind the survivors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ob_r[0] <= {DW{1'b0}};
            ob_r[1] <= {DW{1'b0}};
        end else if (!flush_i) begin
            if (pop_fire_s) begin
                ob_r[0] <= ob_r[1];
            end
            if (inflight_r) begin
                ob_r[ld_idx_s] <= rf_rdata_i;
            end
        end
    end

    twop_rf_fifo_ctrl_chk #(
        .AW (AW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .rf_we    (rf_we_o),
        .rf_re    (rf_re_o),
        .wr_addr  (wr_ptr_r),
        .rd_addr  (rd_ptr_r),
        .inflight (inflight_r),
        .ob_cnt   (ob_cnt_r),
        .count    (count_o)
    );

endmodule

// Invariant checker: RF port collisions, output-buffer overflow and occupancy bound.
module twop_rf_fifo_ctrl_chk #(
    parameter int AW = 6
) (
    input logic          clk,
    input logic          rst,
    input logic          rf_we,
    input logic          rf_re,
    input logic [AW-1:0] wr_addr,
    input logic [AW-1:0] rd_addr,
    input logic          inflight,
    input logic [1:0]    ob_cnt,
    input logic [AW+1:0] count
);
    localparam logic [AW+1:0] MAX_COUNT = (AW+2)'(2**AW + 2);

    a_no_collision: assert property (@(posedge clk) disable iff (rst)
        !(rf_we && rf_re && (wr_addr == rd_addr)));

    a_ob_room: assert property (@(posedge clk) disable iff (rst)
        !(inflight && (ob_cnt == 2'd2)));

    a_count_max: assert property (@(posedge clk) disable iff (rst)
        (count <= MAX_COUNT));

endmodule

// File: tb/tb_twop_rf_fifo_ctrl.sv
// Directed bench for twop_rf_fifo_ctrl with a behavioural 64x32 RF macro attached.
module tb_twop_rf_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_data_i;
    logic        pop_valid_o;
    logic        pop_ready_i;
    logic [31:0] pop_data_o;
    logic [7:0]  count_o;
    logic        rf_we_o;
    logic [5:0]  rf_wr_addr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_re_o;
    logic [5:0]  rf_rd_addr_o;
    logic [31:0] rf_rdata_i;

    int vectors;
    int miscompares;

    logic [31:0] rf_mem [0:63];
    logic [5:0]  exp_wa;
    logic [5:0]  exp_ra;

    twop_rf_fifo_ctrl #(
        .DW (32),
        .AW (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_data_i  (push_data_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_data_o   (pop_data_o),
        .count_o      (count_o),
        .rf_we_o      (rf_we_o),
        .rf_wr_addr_o (rf_wr_addr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_re_o      (rf_re_o),
        .rf_rd_addr_o (rf_rd_addr_o),
        .rf_rdata_i   (rf_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RF macro: synchronous write, registered read data one cycle after the read strobe
    always @(posedge clk) begin
        if (rf_we_o) rf_mem[rf_wr_addr_o] <= rf_wdata_o;
        if (rf_re_o) rf_rdata_i <= rf_mem[rf_rd_addr_o];
    end

    // Expected RF addresses: advance on interface handshakes and read strobes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_wa <= 6'd0;
            exp_ra <= 6'd0;
        end else if (flush_i) begin
            exp_wa <= 6'd0;
            exp_ra <= 6'd0;
        end else begin
            if (push_valid_i && push_ready_o) exp_wa <= exp_wa + 6'd1;
            if (rf_re_o) exp_ra <= exp_ra + 6'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
        push_data_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({pop_valid_o, push_ready_o, count_o, rf_we_o, rf_re_o, rf_wr_addr_o, rf_rd_addr_o, pop_data_o}
            !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_in: pv=%b pr=%b cnt=%0d we=%b re=%b wa=%0d ra=%0d d=%h, want 0 1 0 0 0 0 0 0",
                     pop_valid_o, push_ready_o, count_o, rf_we_o, rf_re_o, rf_wr_addr_o, rf_rd_addr_o, pop_data_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({pop_valid_o, push_ready_o, count_o, rf_we_o, rf_re_o} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_after: pv=%b pr=%b cnt=%0d we=%b re=%b, want 0 1 0 0 0",
                     pop_valid_o, push_ready_o, count_o, rf_we_o, rf_re_o);
        end
        tick();
    endtask

    task automatic test_latency();
        push_valid_i = 1'b1; push_data_i = 32'hA5A5_0001; pop_ready_i = 1'b1;
        #1;
        vectors++;
        if ({rf_we_o, rf_re_o, pop_valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL lat_n: we/re/pv=%b want 100", {rf_we_o, rf_re_o, pop_valid_o});
        end
        tick();
        push_valid_i = 1'b0; push_data_i = 32'd0;
        #1;
        vectors++;
        if ({rf_re_o, pop_valid_o, count_o} !== {1'b1, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL lat_n1: re=%b pv=%b cnt=%0d want 1 0 1", rf_re_o, pop_valid_o, count_o);
        end
        tick();
        vectors++;
        if ({rf_re_o, pop_valid_o, count_o} !== {1'b0, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL lat_n2: re=%b pv=%b cnt=%0d want 0 0 1", rf_re_o, pop_valid_o, count_o);
        end
        tick();
        vectors++;
        if ({pop_valid_o, pop_data_o, count_o} !== {1'b1, 32'hA5A5_0001, 8'd1}) begin
            miscompares++;
            $display("FAIL lat_n3: pv=%b d=%h cnt=%0d want 1 a5a50001 1", pop_valid_o, pop_data_o, count_o);
        end
        tick();
        vectors++;
        if ({pop_valid_o, count_o} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL lat_n4: pv=%b cnt=%0d want 0 0", pop_valid_o, count_o);
        end
        pop_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        int acc;
        int popped;
        logic [31:0] expd;
        acc = 0;
        pop_ready_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            push_valid_i = 1'b1; push_data_i = 32'(i);
            #1;
            if (push_ready_o) acc++;
            tick();
        end
        push_valid_i = 1'b0;
        #1;
        vectors++;
        if (acc != 66) begin
            miscompares++;
            $display("FAIL fill_accepted: got %0d want 66", acc);
        end
        vectors++;
        if ({push_ready_o, count_o} !== {1'b0, 8'd66}) begin
            miscompares++;
            $display("FAIL fill_full: pr=%b cnt=%0d want 0 66", push_ready_o, count_o);
        end
        // Push and pop together at maximum occupancy: ready returns one cycle later
        push_valid_i = 1'b1; push_data_i = 32'd100; pop_ready_i = 1'b1;
        #1;
        vectors++;
        if ({push_ready_o, pop_valid_o, pop_data_o, rf_re_o} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL full_pop: pr=%b pv=%b d=%h re=%b want 0 1 0 1", push_ready_o, pop_valid_o, pop_data_o, rf_re_o);
        end
        tick();
        vectors++;
        if ({push_ready_o, count_o, pop_valid_o, pop_data_o} !== {1'b1, 8'd65, 1'b1, 32'd1}) begin
            miscompares++;
            $display("FAIL full_ready_back: pr=%b cnt=%0d pv=%b d=%h want 1 65 1 1",
                     push_ready_o, count_o, pop_valid_o, pop_data_o);
        end
        tick();
        push_valid_i = 1'b0;
        popped = 2;
        for (int c = 0; c < 200 && popped < 67; c++) begin
            #1;
            if (pop_valid_o) begin
                expd = (popped < 66) ? 32'(popped) : 32'd100;
                vectors++;
                if (pop_data_o !== expd) begin
                    miscompares++;
                    $display("FAIL drain_data: got %h want %h", pop_data_o, expd);
                end
                popped++;
            end
            tick();
        end
        vectors++;
        if (popped != 67) begin
            miscompares++;
            $display("FAIL drain_timeout: popped %0d want 67", popped);
        end
        vectors++;
        if ({pop_valid_o, count_o} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL drain_empty: pv=%b cnt=%0d want 0 0", pop_valid_o, count_o);
        end
        pop_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_throughput();
        int pushed;
        int popped;
        bit wrap_seen;
        logic [5:0] prev_wa;
        pushed = 0; popped = 0; wrap_seen = 1'b0; prev_wa = 6'd0;
        pop_ready_i = 1'b1;
        for (int c = 0; c < 300 && popped < 200; c++) begin
            push_valid_i = (pushed < 200);
            push_data_i = 32'h0C00_0000 + 32'(pushed);
            #1;
            if (rf_we_o) begin
                vectors++;
                if (rf_wr_addr_o !== exp_wa) begin
                    miscompares++;
                    $display("FAIL tp_wr_addr: got %0d want %0d", rf_wr_addr_o, exp_wa);
                end
                if (rf_wr_addr_o == 6'd0 && prev_wa == 6'd63) wrap_seen = 1'b1;
                prev_wa = rf_wr_addr_o;
            end
            if (rf_re_o) begin
                vectors++;
                if (rf_rd_addr_o !== exp_ra) begin
                    miscompares++;
                    $display("FAIL tp_rd_addr: got %0d want %0d", rf_rd_addr_o, exp_ra);
                end
            end
            if (c >= 3 && c < 203) begin
                vectors++;
                if (pop_valid_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tp_bubble: cycle %0d pv=%b want 1", c, pop_valid_o);
                end
            end
            if (pop_valid_o) begin
                vectors++;
                if (pop_data_o !== 32'h0C00_0000 + 32'(popped)) begin
                    miscompares++;
                    $display("FAIL tp_data: got %h want %h", pop_data_o, 32'h0C00_0000 + 32'(popped));
                end
                popped++;
            end
            if (push_valid_i && push_ready_o) pushed++;
            tick();
        end
        push_valid_i = 1'b0;
        vectors++;
        if (popped != 200 || !wrap_seen) begin
            miscompares++;
            $display("FAIL tp_done: popped %0d wrap %b want 200 1", popped, wrap_seen);
        end
        pop_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] sb[$];
        logic [31:0] held;
        int pushed;
        int popped;
        bit stall;
        pushed = 0; popped = 0; stall = 1'b0; held = 32'd0;
        for (int c = 0; c < 6000 && popped < 1000; c++) begin
            push_valid_i = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            push_data_i = $urandom;
            pop_ready_i = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (count_o !== 8'(pushed - popped)) begin
                miscompares++;
                $display("FAIL bp_count: got %0d want %0d", count_o, pushed - popped);
            end
            if (stall) begin
                vectors++;
                if (pop_valid_o !== 1'b1 || pop_data_o !== held) begin
                    miscompares++;
                    $display("FAIL bp_hold: pv=%b d=%h want 1 %h", pop_valid_o, pop_data_o, held);
                end
            end
            if (pop_valid_o && pop_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_dup: got %h want nothing", pop_data_o);
                end else begin
                    if (pop_data_o !== sb[0]) begin
                        miscompares++;
                        $display("FAIL bp_data: got %h want %h", pop_data_o, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                popped++;
            end
            if (push_valid_i && push_ready_o) begin
                sb.push_back(push_data_i);
                pushed++;
            end
            stall = pop_valid_o && !pop_ready_i;
            held = pop_data_o;
            tick();
        end
        push_valid_i = 1'b0; pop_ready_i = 1'b0;
        vectors++;
        if (popped != 1000 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL bp_done: popped %0d left %0d want 1000 0", popped, sb.size());
        end
        tick();
    endtask

    task automatic test_flush();
        int n;
        pop_ready_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            push_valid_i = 1'b1; push_data_i = 32'hF000_0000 + 32'(i);
            tick();
        end
        push_valid_i = 1'b0; pop_ready_i = 1'b1;
        #1;
        vectors++;
        if ({pop_valid_o, pop_data_o} !== {1'b1, 32'hF000_0000}) begin
            miscompares++;
            $display("FAIL fl_head: pv=%b d=%h want 1 f0000000", pop_valid_o, pop_data_o);
        end
        tick();
        pop_ready_i = 1'b0; push_valid_i = 1'b1; push_data_i = 32'hDEAD_BEEF; flush_i = 1'b1;
        #1;
        vectors++;
        if ({count_o, push_ready_o, rf_we_o, rf_re_o} !== {8'd10, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL fl_during: cnt=%0d pr=%b we=%b re=%b want 10 0 0 0", count_o, push_ready_o, rf_we_o, rf_re_o);
        end
        tick();
        flush_i = 1'b0; push_valid_i = 1'b0;
        #1;
        vectors++;
        if ({count_o, pop_valid_o} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL fl_after: cnt=%0d pv=%b want 0 0", count_o, pop_valid_o);
        end
        tick();
        push_valid_i = 1'b1; push_data_i = 32'h0000_1234; pop_ready_i = 1'b1;
        #1;
        vectors++;
        if ({rf_we_o, rf_wr_addr_o} !== {1'b1, 6'd0}) begin
            miscompares++;
            $display("FAIL fl_push: we=%b wa=%0d want 1 0", rf_we_o, rf_wr_addr_o);
        end
        tick();
        push_valid_i = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (pop_valid_o && pop_ready_i) begin
                vectors++;
                if (pop_data_o !== 32'h0000_1234) begin
                    miscompares++;
                    $display("FAIL fl_data: got %h want 00001234", pop_data_o);
                end
                n++;
            end
            tick();
        end
        vectors++;
        if (n != 1 || count_o !== 8'd0) begin
            miscompares++;
            $display("FAIL fl_single: pops %0d cnt %0d want 1 0", n, count_o);
        end
        pop_ready_i = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_latency();
        test_fill();
        test_throughput();
        test_back_pressure();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
